// File: rtl/neuron_accumulate.sv
// Neuron accumulate stage: aligns sign/exp/mantissa products to fixed point
// and sums NUM_INPUTS of them into one saturating pre-activation result.
// Ports: Clk, Reset (async, high); InValid/InReady + ProdSign/ProdExp/ProdMant
// in; OutValid/OutReady + Sum/Saturated out.
module neuron_accumulate #(
  parameter int NUM_INPUTS = 4,
  parameter int ACC_W      = 32,
  parameter int FRAC_BITS  = 8,
  parameter int EXP_BIAS   = 30
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic             ProdSign,
  input  logic [5:0]       ProdExp,
  input  logic [11:0]      ProdMant,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [ACC_W-1:0] Sum,
  output logic             Saturated
);

  localparam int CW = $clog2(NUM_INPUTS + 1);
  // wide enough that no left shift of a 12-bit mantissa loses bits
  localparam int MW = ACC_W + 12 + 63 + FRAC_BITS;

  localparam logic [MW-1:0] MAXW =
    {{(MW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MAXP = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MINN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    count;
  logic             accept;
  logic             clear;
  logic signed [15:0] sh;
  logic [15:0]      nsh;
  logic [MW-1:0]    mant_w;
  logic [MW-1:0]    mag;
  logic             clip;
  logic [ACC_W-1:0] mag_a;
  logic [ACC_W-1:0] val;

  logic             v1;
  logic [ACC_W-1:0] val1;
  logic             clip1;

  logic [ACC_W-1:0] acc;
  logic             sat;
  logic [ACC_W:0]   sum_w;
  logic             ovf;
  logic [ACC_W-1:0] acc_nx;

  assign InReady = !Reset && (state == ACCUM)
                && (count < CW'(NUM_INPUTS));
  assign accept  = InValid && InReady;
  assign clear   = (state == DONE) && OutReady;

  assign OutValid  = (state == DONE);
  assign Sum       = acc;
  assign Saturated = sat;

  // alignment: shift amount is exp - bias + frac, may be negative
  always_comb begin
    sh     = 16'(ProdExp) - 16'(EXP_BIAS) + 16'(FRAC_BITS);
    nsh    = -sh;
    mant_w = {{(MW-12){1'b0}}, ProdMant};
    if (!sh[15]) mag = mant_w << sh;
    else         mag = mant_w >> nsh;
    clip  = (mag > MAXW);
    mag_a = clip ? MAXP : mag[ACC_W-1:0];
    val   = ProdSign ? mag_a : -mag_a;
  end

  // saturating add: sign-extend one bit, overflow if top two differ
  always_comb begin
    sum_w  = {acc[ACC_W-1], acc} + {val1[ACC_W-1], val1};
    ovf    = (sum_w[ACC_W] != sum_w[ACC_W-1]);
    acc_nx = sum_w[ACC_W-1:0];
    if (ovf) acc_nx = sum_w[ACC_W] ? MINN : MAXP;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM: if (accept && count == CW'(NUM_INPUTS - 1))
               state_nx = DRAIN;
      DRAIN: if (!v1) state_nx = DONE;
      DONE:  if (OutReady) state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ACCUM;
      count <= '0;
      v1    <= 1'b0;
      val1  <= '0;
      clip1 <= 1'b0;
      acc   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nx;
      v1    <= accept;
      if (accept) begin
        val1  <= val;
        clip1 <= clip;
      end
      if (clear) begin
        acc   <= '0;
        sat   <= 1'b0;
        count <= '0;
      end else begin
        if (v1) begin
          acc <= acc_nx;
          sat <= sat | clip1 | ovf;
        end
        if (accept) count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neuron_accumulate.sv
// Directed bench for neuron_accumulate with a frame-sum scoreboard.
// Products are modelled independently; results checked on OutValid.
module tb_neuron_accumulate;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic        ProdSign = 1'b0;
  logic [5:0]  ProdExp = '0;
  logic [11:0] ProdMant = '0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] Sum;
  logic        Saturated;

  neuron_accumulate dut (
    .Clk(Clk), .Reset(Reset),
    .InValid(InValid), .InReady(InReady),
    .ProdSign(ProdSign), .ProdExp(ProdExp), .ProdMant(ProdMant),
    .OutValid(OutValid), .OutReady(OutReady),
    .Sum(Sum), .Saturated(Saturated)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] sum;
    logic        sat;
  } exp_t;

  exp_t sb[$];

  int     total = 0;
  int     passed = 0;
  longint m_acc = 0;
  bit     m_sat = 0;

  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic longint align(bit s, int e, int m, output bit c);
    int     shv;
    longint mg;
    shv = e - 30 + 8;
    if (shv >= 0)        mg = longint'(m) << shv;
    else if (shv <= -12) mg = 0;
    else                 mg = longint'(m) >> (-shv);
    c = (mg > MAXP);
    if (c) mg = MAXP;
    return s ? mg : -mg;
  endfunction

  task automatic send(bit s, int e, int m);
    int     n;
    bit     c;
    longint t;
    @(negedge Clk);
    InValid  = 1'b1;
    ProdSign = s;
    ProdExp  = 6'(e);
    ProdMant = 12'(m);
    n = 0;
    while (!InReady && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!InReady) chk("send_ready_timeout", 32'(InReady), 32'd1);
    @(posedge Clk);
    t = m_acc + align(s, e, m, c);
    if (c) m_sat = 1;
    if (t > MAXP) begin t = MAXP; m_sat = 1; end
    if (t < MINN) begin t = MINN; m_sat = 1; end
    m_acc = t;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge Clk);
      InValid  = 1'b0;
      ProdMant = 12'hFFF;
      @(posedge Clk);
    end
  endtask

  task automatic frame_end();
    exp_t e;
    e.sum = m_acc[31:0];
    e.sat = m_sat;
    sb.push_back(e);
    m_acc = 0;
    m_sat = 0;
  endtask

  // called right after the last accepting edge
  task automatic wait_out(string tag);
    int   n;
    exp_t e;
    @(negedge Clk);
    InValid = 1'b0;
    n = 1;
    while (!OutValid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, Sum, e.sum);
      chk({tag, "_sat"}, 32'(Saturated), 32'(e.sat));
    end
  endtask

  task automatic handshake(string tag);
    OutReady = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    OutReady = 1'b0;
    chk({tag, "_hs_ov"}, 32'(OutValid), 32'd0);
    chk({tag, "_hs_ir"}, 32'(InReady), 32'd1);
    chk({tag, "_hs_sum"}, Sum, 32'd0);
    chk({tag, "_hs_sat"}, 32'(Saturated), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;

    // reset state
    @(negedge Clk);
    chk("rst_ov", 32'(OutValid), 32'd0);
    chk("rst_sum", Sum, 32'd0);
    chk("rst_sat", 32'(Saturated), 32'd0);
    chk("rst_ir", 32'(InReady), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1 chk("rel_ir", 32'(InReady), 32'd1);

    // back-to-back mixed signs
    send(1, 30, 3); send(0, 30, 1); send(1, 30, 3); send(0, 30, 1);
    frame_end();
    wait_out("t1");
    chk("t1_const", Sum, 32'h0000_0400);
    handshake("t1");

    // right shifts and truncation to zero
    repeat (4) send(1, 20, 7);
    frame_end();
    wait_out("t2a");
    chk("t2a_const", Sum, 32'd4);
    handshake("t2a");
    send(1, 10, 4095); send(1, 20, 7); send(1, 10, 4095); send(1, 20, 7);
    frame_end();
    wait_out("t2b");
    chk("t2b_const", Sum, 32'd2);
    handshake("t2b");

    // positive and negative saturation
    send(1, 62, 4095);
    repeat (3) send(1, 30, 1);
    frame_end();
    wait_out("t3p");
    chk("t3p_const", Sum, 32'h7FFF_FFFF);
    chk("t3p_sat1", 32'(Saturated), 32'd1);
    handshake("t3p");
    send(0, 62, 4095);
    repeat (3) send(0, 30, 1);
    frame_end();
    wait_out("t3n");
    chk("t3n_const", Sum, 32'h8000_0000);
    handshake("t3n");

    // output backpressure, input offered but ignored in DONE
    repeat (4) send(1, 30, 2);
    frame_end();
    wait_out("t4");
    held = Sum;
    InValid  = 1'b1;
    ProdSign = 1'b1;
    ProdExp  = 6'd40;
    ProdMant = 12'd99;
    repeat (5) begin
      @(negedge Clk);
      chk("t4_ov_hold", 32'(OutValid), 32'd1);
      chk("t4_sum_hold", Sum, held);
      chk("t4_ir_low", 32'(InReady), 32'd0);
    end
    InValid = 1'b0;
    handshake("t4");
    repeat (4) send(0, 30, 1);
    frame_end();
    wait_out("t4b");
    chk("t4b_const", Sum, 32'hFFFF_FC00);
    handshake("t4b");

    // bubbles 1,0,0,1,0,1,1
    send(1, 30, 1); idle(2);
    send(1, 30, 1); idle(1);
    send(1, 30, 1); send(1, 30, 1);
    frame_end();
    wait_out("t5");
    chk("t5_const", Sum, 32'h0000_0400);
    handshake("t5");

    // reset mid-frame
    send(1, 30, 5); send(1, 30, 5);
    @(negedge Clk);
    InValid = 1'b0;
    Reset = 1'b1;
    #1;
    chk("t6_rst_ov", 32'(OutValid), 32'd0);
    chk("t6_rst_sum", Sum, 32'd0);
    chk("t6_rst_sat", 32'(Saturated), 32'd0);
    chk("t6_rst_ir", 32'(InReady), 32'd0);
    m_acc = 0;
    m_sat = 0;
    @(negedge Clk);
    Reset = 1'b0;
    send(1, 30, 1); send(1, 30, 2); send(0, 30, 1); send(1, 30, 1);
    frame_end();
    wait_out("t6");
    chk("t6_const", Sum, 32'h0000_0300);
    handshake("t6");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
